// File: rtl/checkpoint_seq_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : checkpoint_seq_monitor                                         |
// | Purpose : checks an ordered list of stable checkpoint codes on a bus     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module checkpoint_seq_monitor #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 8,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int TICK_INTERVAL  = 1000,
  parameter int CNT_W          = 32
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [WIDTH-1:0]                              checkbits,
  input  logic                                          seq_wr_en,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]  seq_wr_addr,
  input  logic [WIDTH-1:0]                              seq_wr_data,
  input  logic [$clog2(DEPTH+1)-1:0]                    seq_len,
  input  logic                                          strict,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          pass,
  output logic                                          fail,
  output logic [1:0]                                    fail_cause,
  output logic [$clog2(DEPTH+1)-1:0]                    step_idx,
  output logic                                          step_pulse,
  output logic                                          tick,
  output logic [CNT_W-1:0]                              cycle_count
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_iw = $clog2(DEPTH + 1);
  localparam int c_sw = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int c_tw = (TICK_INTERVAL > 1) ? $clog2(TICK_INTERVAL) : 1;
  localparam logic [c_sw-1:0]  c_stable_max   = c_sw'(STABLE_CYCLES - 1);
  localparam logic [c_tw-1:0]  c_tick_last    = c_tw'(TICK_INTERVAL - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_iw-1:0]  c_depth        = c_iw'(DEPTH);
  localparam logic [1:0] c_cause_timeout = 2'd1;
  localparam logic [1:0] c_cause_order   = 2'd2;
  localparam logic [1:0] c_cause_len     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_seq [DEPTH];
  logic [WIDTH-1:0]  r_sample, w_sample_d;
  logic [c_sw-1:0]   r_stable_cnt, w_stable_d, w_stable_nxt;
  logic              r_first, w_first_d;
  logic [c_iw-1:0]   r_len, w_len_d;
  logic              r_strict, w_strict_d;
  logic [c_iw-1:0]   r_step_idx, w_step_nxt;
  logic [CNT_W-1:0]  r_cycle_cnt, w_cycle_nxt;
  logic [c_tw-1:0]   r_tick_cnt, w_tick_cnt_nxt;
  logic              r_pass, w_pass_d, r_fail, w_fail_d;
  logic [1:0]        r_cause, w_cause_d;
  logic              r_pulse, w_pulse_d, r_tick, w_tick_d;
  logic [c_aw-1:0]   w_cur_addr, w_prev_addr;
  logic              w_same, w_qual, w_match, w_prev, w_last, w_timeout;

  // The first RUN sample always opens a fresh stable run, whatever s_q held.
  always_comb begin
    w_same       = !r_first && (checkbits == r_sample);
    w_stable_nxt = '0;
    if (w_same) begin
      w_stable_nxt = (r_stable_cnt == c_stable_max) ? r_stable_cnt : r_stable_cnt + 1'b1;
    end
    w_qual      = (w_stable_nxt == c_stable_max) && !(w_same && (r_stable_cnt == c_stable_max));
    w_cur_addr  = r_step_idx[c_aw-1:0];
    w_prev_addr = w_cur_addr - 1'b1;
    w_match     = w_qual && (checkbits == r_seq[w_cur_addr]);
    w_prev      = w_qual && (r_step_idx != '0) && (checkbits == r_seq[w_prev_addr]);
    w_last      = (r_step_idx == r_len - 1'b1);
    w_timeout   = (r_cycle_cnt == c_timeout_last);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sample_d     = r_sample;
    w_stable_d     = r_stable_cnt;
    w_first_d      = r_first;
    w_len_d        = r_len;
    w_strict_d     = r_strict;
    w_step_nxt     = r_step_idx;
    w_cycle_nxt    = r_cycle_cnt;
    w_tick_cnt_nxt = r_tick_cnt;
    w_pass_d       = r_pass;
    w_fail_d       = r_fail;
    w_cause_d      = r_cause;
    w_pulse_d      = 1'b0;
    w_tick_d       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_sample_d     = checkbits;
        w_stable_d     = w_stable_nxt;
        w_first_d      = 1'b0;
        w_cycle_nxt    = r_cycle_cnt + 1'b1;
        w_tick_cnt_nxt = (r_tick_cnt == c_tick_last) ? '0 : r_tick_cnt + 1'b1;
        if (w_match) begin
          w_step_nxt = r_step_idx + 1'b1;
          w_pulse_d  = 1'b1;
        end
        if (w_match && w_last) begin
          w_state_nxt = S_PASS;
          w_pass_d    = 1'b1;
        end else if (w_qual && !w_match && !w_prev && r_strict) begin
          w_state_nxt = S_FAIL;
          w_fail_d    = 1'b1;
          w_cause_d   = c_cause_order;
        end else if (w_timeout) begin
          w_state_nxt = S_FAIL;
          w_fail_d    = 1'b1;
          w_cause_d   = c_cause_timeout;
        end else begin
          w_tick_d = (r_tick_cnt == c_tick_last);
        end
      end
      default: begin
        if (start) begin
          if ((seq_len == '0) || (seq_len > c_depth)) begin
            w_state_nxt = S_FAIL;
            w_pass_d    = 1'b0;
            w_fail_d    = 1'b1;
            w_cause_d   = c_cause_len;
          end else begin
            w_state_nxt    = S_RUN;
            w_len_d        = seq_len;
            w_strict_d     = strict;
            w_first_d      = 1'b1;
            w_stable_d     = '0;
            w_step_nxt     = '0;
            w_cycle_nxt    = '0;
            w_tick_cnt_nxt = '0;
            w_pass_d       = 1'b0;
            w_fail_d       = 1'b0;
            w_cause_d      = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sample     <= '0;
      r_stable_cnt <= '0;
      r_first      <= 1'b0;
      r_len        <= '0;
      r_strict     <= 1'b0;
      r_step_idx   <= '0;
      r_cycle_cnt  <= '0;
      r_tick_cnt   <= '0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_cause      <= '0;
      r_pulse      <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample     <= w_sample_d;
      r_stable_cnt <= w_stable_d;
      r_first      <= w_first_d;
      r_len        <= w_len_d;
      r_strict     <= w_strict_d;
      r_step_idx   <= w_step_nxt;
      r_cycle_cnt  <= w_cycle_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_pass       <= w_pass_d;
      r_fail       <= w_fail_d;
      r_cause      <= w_cause_d;
      r_pulse      <= w_pulse_d;
      r_tick       <= w_tick_d;
    end
  end

  // The sequence table is frozen while a run is in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_seq[i] <= '0;
      end
    end else if (seq_wr_en && (r_state != S_RUN)) begin
      r_seq[seq_wr_addr] <= seq_wr_data;
    end
  end

  assign busy        = (r_state == S_RUN);
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign fail_cause  = r_cause;
  assign step_idx    = r_step_idx;
  assign step_pulse  = r_pulse;
  assign tick        = r_tick;
  assign cycle_count = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_seq_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_checkpoint_seq_monitor                                      |
// | Purpose : bench for checkpoint_seq_monitor (two parameter sets)          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_checkpoint_seq_monitor;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1, start = 1'b0, seq_wr_en = 1'b0, strict = 1'b0;
  logic [2:0]  seq_wr_addr = '0;
  logic [15:0] seq_wr_data = '0, checkbits = '0;
  logic [3:0]  seq_len = '0;

  logic        a_busy, a_pass, a_fail, a_pulse, a_tick;
  logic [1:0]  a_cause;
  logic [3:0]  a_step;
  logic [15:0] a_cnt;
  logic        b_busy, b_pass, b_fail, b_pulse, b_tick;
  logic [1:0]  b_cause;
  logic [3:0]  b_step;
  logic [31:0] b_cnt;

  checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(8), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(50),
                           .TICK_INTERVAL(10), .CNT_W(16)) u_dut_a (
    .clock(clock), .reset(reset), .checkbits(checkbits), .seq_wr_en(seq_wr_en),
    .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data), .seq_len(seq_len),
    .strict(strict), .start(start), .busy(a_busy), .pass(a_pass), .fail(a_fail),
    .fail_cause(a_cause), .step_idx(a_step), .step_pulse(a_pulse), .tick(a_tick),
    .cycle_count(a_cnt));

  checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(8), .STABLE_CYCLES(3), .TIMEOUT_CYCLES(60),
                           .TICK_INTERVAL(7), .CNT_W(32)) u_dut_b (
    .clock(clock), .reset(reset), .checkbits(checkbits), .seq_wr_en(seq_wr_en),
    .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data), .seq_len(seq_len),
    .strict(strict), .start(start), .busy(b_busy), .pass(b_pass), .fail(b_fail),
    .fail_cause(b_cause), .step_idx(b_step), .step_pulse(b_pulse), .tick(b_tick),
    .cycle_count(b_cnt));

  // Reference: run_len counts how long the bus has held its value during this run.
  typedef struct {
    bit               run;
    bit               pass;
    bit               fail;
    int               cause;
    int               idx;
    int               cnt;
    bit               pulse;
    bit               tick;
    int               run_len;
    logic [15:0]      last;
    int               len;
    bit               strict;
    logic [7:0][15:0] ram;
  } mdl_t;

  typedef struct {
    logic [15:0] code;
    int          hold;
    bit          wr;
    int          exp_step;
    bit          exp_pass;
  } vec_t;

  mdl_t ma, mb;
  vec_t tbl [7];
  int   checks = 0;
  int   errors = 0;
  int   tick_q[$];
  bit   tick_rec = 1'b0;

  function automatic mdl_t mstep(mdl_t m, int s, int t, int ti);
    mdl_t n;
    int   rl;
    bit   q, hit, prev;
    n = m;
    n.pulse = 1'b0;
    n.tick  = 1'b0;
    if (reset) begin
      n.run = 0; n.pass = 0; n.fail = 0; n.cause = 0; n.idx = 0; n.cnt = 0;
      n.run_len = 0; n.last = '0; n.len = 0; n.strict = 0; n.ram = '0;
      return n;
    end
    if (!m.run && seq_wr_en) n.ram[seq_wr_addr] = seq_wr_data;
    if (m.run) begin
      rl   = (m.run_len > 0 && checkbits == m.last) ? m.run_len + 1 : 1;
      q    = (rl == s);
      hit  = q && (checkbits == m.ram[m.idx]);
      prev = q && (m.idx > 0) && (checkbits == m.ram[m.idx-1]);
      n.run_len = rl;
      n.last    = checkbits;
      n.cnt     = m.cnt + 1;
      if (hit) begin
        n.idx   = m.idx + 1;
        n.pulse = 1'b1;
      end
      if (hit && m.idx == m.len - 1) begin
        n.run = 0; n.pass = 1;
      end else if (q && !hit && !prev && m.strict) begin
        n.run = 0; n.fail = 1; n.cause = 2;
      end else if (m.cnt == t - 1) begin
        n.run = 0; n.fail = 1; n.cause = 1;
      end else begin
        n.tick = (n.cnt % ti == 0);
      end
    end else if (start) begin
      if (seq_len == 0 || seq_len > 8) begin
        n.pass = 0; n.fail = 1; n.cause = 3;
      end else begin
        n.run = 1; n.idx = 0; n.cnt = 0; n.pass = 0; n.fail = 0; n.cause = 0;
        n.run_len = 0; n.len = int'(seq_len); n.strict = strict;
      end
    end
    return n;
  endfunction

  task automatic cmp(string nm, mdl_t m, logic busy, logic pass, logic fail, logic [1:0] cause,
                     logic [3:0] step, logic pulse, logic tck, logic [31:0] cnt);
    checks++;
    if (busy !== m.run || pass !== m.pass || fail !== m.fail || cause !== 2'(m.cause) ||
        step !== 4'(m.idx) || pulse !== m.pulse || tck !== m.tick || cnt !== 32'(m.cnt)) begin
      errors++;
      $display("FAIL model_%s t=%0t: dut busy=%b pass=%b fail=%b cause=%0d step=%0d pulse=%b tick=%b cnt=%0d; expected busy=%b pass=%b fail=%b cause=%0d step=%0d pulse=%b tick=%b cnt=%0d",
               nm, $time, busy, pass, fail, cause, step, pulse, tck, cnt,
               m.run, m.pass, m.fail, m.cause, m.idx, m.pulse, m.tick, m.cnt);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    mdl_t na, nb;
    na = mstep(ma, 2, 50, 10);
    nb = mstep(mb, 3, 60, 7);
    @(posedge clock);
    #1;
    ma = na;
    mb = nb;
    if (tick_rec && a_tick) tick_q.push_back(int'(a_cnt));
    cmp("A", ma, a_busy, a_pass, a_fail, a_cause, a_step, a_pulse, a_tick, {16'd0, a_cnt});
    cmp("B", mb, b_busy, b_pass, b_fail, b_cause, b_step, b_pulse, b_tick, b_cnt);
  endtask

  task automatic hold(logic [15:0] code, int n);
    checkbits = code;
    repeat (n) cyc();
  endtask

  task automatic wr(logic [2:0] addr, logic [15:0] data);
    seq_wr_en = 1'b1; seq_wr_addr = addr; seq_wr_data = data;
    cyc();
    seq_wr_en = 1'b0;
  endtask

  task automatic go(int len, bit st);
    seq_len = 4'(len); strict = st; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'hA040, 5, 1'b0, 1, 1'b0};
    tbl[1] = '{16'h0000, 2, 1'b1, 1, 1'b0};
    tbl[2] = '{16'hA041, 5, 1'b0, 2, 1'b0};
    tbl[3] = '{16'h0000, 2, 1'b0, 2, 1'b0};
    tbl[4] = '{16'hA042, 5, 1'b0, 3, 1'b0};
    tbl[5] = '{16'h0000, 2, 1'b0, 3, 1'b0};
    tbl[6] = '{16'hA090, 5, 1'b0, 4, 1'b1};

    cyc(); cyc();
    reset = 1'b0;
    chk("rst_busy", a_busy, 0); chk("rst_pass", a_pass, 0); chk("rst_fail", a_fail, 0);
    chk("rst_step", a_step, 0); chk("rst_cnt", a_cnt, 0);

    // Basic pass; the write during the run must be ignored.
    wr(3'd0, 16'hA040); wr(3'd1, 16'hA041); wr(3'd2, 16'hA042); wr(3'd3, 16'hA090);
    checkbits = 16'h0000;
    go(4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checkbits = tbl[i].code;
      if (tbl[i].wr) begin
        seq_wr_en = 1'b1; seq_wr_addr = 3'd1; seq_wr_data = 16'hFFFF;
      end
      cyc();
      seq_wr_en = 1'b0;
      repeat (tbl[i].hold - 1) cyc();
      chk($sformatf("tbl_step_%0d", i), a_step, tbl[i].exp_step);
      chk($sformatf("tbl_pass_%0d", i), a_pass, tbl[i].exp_pass);
    end
    chk("pass_fail", a_fail, 0); chk("pass_busy", a_busy, 0);
    chk("pass_cnt", a_cnt, 23); chk("pass_b", b_pass, 1);
    hold(16'h0000, 3);
    chk("pass_cnt_frozen", a_cnt, 23);

    // Rerun with no gaps proves the RAM kept A041.
    checkbits = 16'hA040;
    go(4, 1'b0);
    hold(16'hA040, 3); hold(16'hA041, 3); hold(16'hA042, 3); hold(16'hA090, 3);
    chk("rerun_step", a_step, 4); chk("rerun_pass", a_pass, 1); chk("rerun_b", b_pass, 1);

    // Strict order failure.
    checkbits = 16'hA040;
    go(4, 1'b1);
    hold(16'hA040, 3); hold(16'hA042, 3);
    chk("order_fail", a_fail, 1); chk("order_cause", a_cause, 2);
    chk("order_step", a_step, 1); chk("order_pass", a_pass, 0); chk("order_b_cause", b_cause, 2);

    // Timeout with heartbeat ticks.
    checkbits = 16'hA040;
    tick_q.delete();
    go(4, 1'b0);
    tick_rec = 1'b1;
    repeat (49) cyc();
    chk("to_pre_fail", a_fail, 0); chk("to_pre_cnt", a_cnt, 49);
    cyc();
    chk("to_fail", a_fail, 1); chk("to_cause", a_cause, 1);
    chk("to_step", a_step, 1); chk("to_cnt", a_cnt, 50);
    repeat (10) cyc();
    tick_rec = 1'b0;
    chk("to_b_cause", b_cause, 1);
    chk("tick_count", tick_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < tick_q.size()) chk($sformatf("tick_at_%0d", i), tick_q[i], 10 * (i + 1));
      else chk($sformatf("tick_at_%0d", i), -1, 10 * (i + 1));
    end

    // One-cycle glitch must not advance the STABLE_CYCLES=3 monitor.
    checkbits = 16'hA040;
    go(4, 1'b0);
    hold(16'hA040, 4); hold(16'hA041, 1); hold(16'hA040, 3);
    chk("glitch_b_step", b_step, 1); chk("glitch_a_step", a_step, 1);
    hold(16'hA041, 3);
    chk("glitch_b_adv", b_step, 2);
    hold(16'hA042, 3); hold(16'hA090, 3);
    chk("glitch_b_pass", b_pass, 1);

    // Bad lengths.
    go(0, 1'b0);
    chk("len0_fail", a_fail, 1); chk("len0_cause", a_cause, 3);
    chk("len0_busy", a_busy, 0); chk("len0_pass", a_pass, 0);
    go(9, 1'b0);
    chk("len9_cause", b_cause, 3);

    // Reset in the middle of a run.
    checkbits = 16'hA040;
    go(4, 1'b0);
    hold(16'hA040, 4);
    chk("mid_busy", a_busy, 1); chk("mid_step", a_step, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rstrun_busy", a_busy, 0); chk("rstrun_pass", a_pass, 0); chk("rstrun_fail", a_fail, 0);
    chk("rstrun_step", a_step, 0); chk("rstrun_b_step", b_step, 0); chk("rstrun_cnt", a_cnt, 0);

    // Final match on the timeout edge wins.
    wr(3'd0, 16'hA040);
    checkbits = 16'h0000;
    go(1, 1'b0);
    hold(16'h0000, 48); hold(16'hA040, 2);
    chk("edge_pass", a_pass, 1); chk("edge_fail", a_fail, 0);
    chk("edge_cause", a_cause, 0); chk("edge_cnt", a_cnt, 50);
    hold(16'hA040, 2);
    chk("edge_b_pass", b_pass, 1);

    // Randomized runs against the reference.
    for (int r = 0; r < 40; r++) begin
      int          guard;
      int          len;
      int          sel;
      logic [15:0] code;
      repeat ($urandom_range(0, 3)) wr(3'($urandom_range(0, 7)), {8'hA0, 8'($urandom_range(0, 7))});
      if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 1) ? 0 : $urandom_range(9, 15);
      else len = $urandom_range(1, 4);
      go(len, 1'($urandom_range(0, 1)));
      guard = 0;
      while ((ma.run || mb.run || a_busy || b_busy) && guard < 90) begin
        sel = $urandom_range(0, 9);
        if (sel < 5) code = ma.run ? ma.ram[ma.idx] : (mb.run ? mb.ram[mb.idx] : 16'h0000);
        else if (sel < 8) code = {8'hA0, 8'($urandom_range(0, 7))};
        else code = 16'h0000;
        seq_wr_en   = ($urandom_range(0, 9) == 0);
        seq_wr_addr = 3'($urandom_range(0, 7));
        seq_wr_data = 16'($urandom);
        sel = $urandom_range(1, 4);
        hold(code, sel);
        seq_wr_en = 1'b0;
        guard += sel;
      end
      chk($sformatf("rand_bound_%0d", r), (guard >= 90) ? 1 : 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
Synthesizable, parametrised checkpoint-sequence monitor for mgmt_soc test benches and on-chip self-test. It watches a checkpoint bus (typically mprj_io[31:16]) and checks an ordered list of up to DEPTH programmed codes. Each code must be stable for STABLE_CYCLES samples before it counts. It reports pass, fail with cause, progress index, step pulses and periodic heartbeat ticks, so benches become thin wrappers and silicon self-test can reuse the same logic.

Parameters:
WIDTH, 16, checkpoint bus width
DEPTH, 8, maximum programmable sequence length (>=1)
STABLE_CYCLES, 2, consecutive equal samples needed to qualify a value (>=1)
TIMEOUT_CYCLES, 25000, run cycles before timeout failure
TICK_INTERVAL, 1000, cycles between heartbeat tick pulses
CNT_W, 32, cycle counter width; must hold TIMEOUT_CYCLES

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
checkbits  in  WIDTH  observed checkpoint bus
seq_wr_en  in  1  write one sequence entry
seq_wr_addr  in  $clog2(DEPTH)  entry index
seq_wr_data  in  WIDTH  expected code
seq_len  in  $clog2(DEPTH+1)  number of valid entries, sampled at start
strict  in  1  1 = unexpected qualified code fails; sampled at start
start  in  1  one-cycle start pulse
busy  out  1  high in RUN
pass  out  1  sticky pass
fail  out  1  sticky fail
fail_cause  out  2  0 none, 1 timeout, 2 order, 3 bad length
step_idx  out  $clog2(DEPTH+1)  entries matched so far
step_pulse  out  1  one-cycle pulse per match
tick  out  1  one-cycle pulse every TICK_INTERVAL run cycles
cycle_count  out  CNT_W  cycles since start, frozen at PASS/FAIL

Behaviour:
- Reset values: all outputs 0; state IDLE; sequence RAM cleared to 0; sample register and stable counter cleared.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL persist until reset or the next start.
- IDLE/PASS/FAIL + start:
  - seq_len==0 or seq_len>DEPTH -> FAIL with cause 3, next cycle.
  - otherwise -> RUN, and the following are cleared: step_idx, cycle_count, stable counter, pass, fail, fail_cause.
- seq_wr_en is honoured in every state except RUN; it is ignored in RUN. start is ignored in RUN.
- Qualification in RUN, every cycle:
  - s_q <= checkbits.
  - stable_cnt <= (checkbits==s_q) ? sat(stable_cnt+1) : 0.
  - A value qualifies on the edge where stable_cnt reaches STABLE_CYCLES-1 with checkbits==s_q. With STABLE_CYCLES==1, any change qualifies immediately, and the first RUN cycle always qualifies.
  - Each stable run qualifies at most once.
- On qualification:
  - value == seq[step_idx] -> step_idx+1 and step_pulse next cycle. If that was the last entry (step_idx==seq_len-1) -> PASS.
  - value == seq[step_idx-1] (re-qualify of the previous code) -> ignored.
  - any other value: strict=1 -> FAIL with cause 2; strict=0 -> ignored.
- cycle_count increments every RUN cycle. tick pulses when cycle_count+1 is a nonzero multiple of TICK_INTERVAL.
- Timeout: cycle_count==TIMEOUT_CYCLES-1 with no completing match -> FAIL with cause 1.
- Priority on the same edge: completing match > order fail > timeout.
- busy drops the cycle that pass or fail rises.
- Reset mid-RUN: returns to IDLE with all outputs 0. No pass/fail is emitted.
- Latency: match, pass, fail and tick are all registered, visible one cycle after the deciding edge.

Test Plan:
- Program seq {A040,A041,A042,A090}, len=4, STABLE_CYCLES=2, strict=0. Drive each code for 5 cycles with 0000 gaps -> step_pulse x4, step_idx=4, pass=1, fail=0, cycle_count frozen.
- Same sequence, strict=1, drive A040 then A042 -> fail=1, fail_cause=2, step_idx=1.
- TIMEOUT_CYCLES=50, drive only A040 -> fail=1, fail_cause=1 one cycle after cycle_count==49, step_idx=1. TICK_INTERVAL=10 -> ticks at counts 10,20,30,40.
- One-cycle glitch of A041 between stable A040 runs, STABLE_CYCLES=3 -> no advance, step_idx stays 1. Then A041 held 3 cycles -> step_idx=2.
- start with seq_len=0 -> fail_cause=3. Then, mid-RUN, assert reset for 1 cycle -> busy, pass, fail, step_idx all 0. seq_wr_en during RUN leaves the RAM unchanged, checked by a rerun.
- Final code qualifies on the same edge as timeout -> pass=1, fail=0.
